// File: rtl/mem_stage_pkg.sv
// Shared state type and default parameters for the memory stage and its SRAM controller.
package mem_stage_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int ADDR_BASE_DEF = 1024;
    localparam int SRAM_WAIT_DEF = 4;
    localparam int SRAM_AW_DEF   = 18;
    localparam int SRAM_DW       = 16;

endpackage

// File: rtl/sram_ctrl.sv
// Two-phase half-word SRAM sequencer: FSM, per-phase wait counter, strobes and read capture.
module sram_ctrl
    import mem_stage_pkg::*;
#(
    parameter int SRAM_WAIT = SRAM_WAIT_DEF,
    parameter int SRAM_AW   = SRAM_AW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_i,
    input  logic               rd_i,
    input  logic               wr_i,
    input  logic [SRAM_AW-2:0] wa_i,
    input  logic [31:0]        wdata_i,
    input  logic [SRAM_DW-1:0] rdata_i,
    output state_e             state_o,
    output logic [SRAM_AW-1:0] addr_o,
    output logic [SRAM_DW-1:0] wdata_o,
    output logic               we_n_o,
    output logic               oe_n_o,
    output logic [31:0]        data_o
);

    localparam int            CW       = $clog2(SRAM_WAIT);
    localparam logic [CW-1:0] CNT_LAST = CW'(SRAM_WAIT - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   data_q, data_d;
    logic          in_phase;
    logic          last;
    logic          is_hi;

    assign in_phase = (state_q == LO) || (state_q == HI);
    assign is_hi    = (state_q == HI);
    assign last     = (cnt_q == CNT_LAST);

    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        data_d  = data_q;
        addr_o  = '0;
        wdata_o = '0;
        we_n_o  = 1'b1;
        oe_n_o  = 1'b1;

        if (in_phase) begin
            cnt_d  = last ? '0 : cnt_q + 1'b1;
            addr_o = {wa_i, is_hi};
            // Write wins when both enables are set; the last cycle of each phase is the hold cycle.
            if (wr_i) begin
                wdata_o = is_hi ? wdata_i[31:16] : wdata_i[15:0];
                we_n_o  = last;
            end else if (rd_i) begin
                oe_n_o = 1'b0;
                if (last) begin
                    if (is_hi) data_d[31:16] = rdata_i;
                    else       data_d[15:0]  = rdata_i;
                end
            end
        end

        case (state_q)
            IDLE:    if (start_i) state_d = LO;
            LO:      if (last) state_d = HI;
            HI:      if (last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignment so all flops update together on the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    assign state_o = state_q;
    assign data_o  = data_q;

endmodule

// File: rtl/mem_stage.sv
// ARM pipeline memory stage: pass-through to WB, address translation, SRAM access and stall.
// Define MEM_READ_HIT_BUF_EN to add a one-entry read buffer that answers repeat reads with no stall.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_BASE = ADDR_BASE_DEF,
    parameter int SRAM_WAIT = SRAM_WAIT_DEF,
    parameter int SRAM_AW   = SRAM_AW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wb_en_in,
    input  logic               mem_read_en_in,
    input  logic               mem_write_en_in,
    input  logic [31:0]        alu_res_in,
    input  logic [31:0]        val_Rm,
    input  logic [3:0]         dest_in,
    output logic               wb_en,
    output logic               mem_read_en,
    output logic [31:0]        alu_res,
    output logic [3:0]         dest,
    output logic [31:0]        mem_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_wdata,
    input  logic [SRAM_DW-1:0] sram_rdata,
    output logic               sram_we_n,
    output logic               sram_oe_n
);

    logic [SRAM_AW-2:0] wa;
    logic               mem_req;
    logic               hit;
    logic               start;
    state_e             state;
    logic [31:0]        data_reg;

    // Truncation to SRAM_AW-1 bits makes out-of-range addresses wrap.
    assign wa      = (SRAM_AW-1)'((alu_res_in - 32'(ADDR_BASE)) >> 2);
    assign mem_req = mem_read_en_in | mem_write_en_in;
    assign start   = (state == IDLE) && mem_req && !hit;
    assign ready   = ((state == IDLE) && !mem_req) || (state == DONE) || hit;

    assign wb_en       = wb_en_in & ready;
    assign mem_read_en = mem_read_en_in;
    assign alu_res     = alu_res_in;
    assign dest        = dest_in;

    sram_ctrl #(
        .SRAM_WAIT(SRAM_WAIT),
        .SRAM_AW  (SRAM_AW)
    ) u_sram_ctrl (
        .clk    (clk),
        .rst    (rst),
        .start_i(start),
        .rd_i   (mem_read_en_in),
        .wr_i   (mem_write_en_in),
        .wa_i   (wa),
        .wdata_i(val_Rm),
        .rdata_i(sram_rdata),
        .state_o(state),
        .addr_o (sram_addr),
        .wdata_o(sram_wdata),
        .we_n_o (sram_we_n),
        .oe_n_o (sram_oe_n),
        .data_o (data_reg)
    );

`ifdef MEM_READ_HIT_BUF_EN
    logic               rd_only;
    logic               buf_valid_q, buf_valid_d;
    logic [SRAM_AW-2:0] buf_tag_q, buf_tag_d;
    logic [31:0]        buf_data_q, buf_data_d;

    assign rd_only = mem_read_en_in & ~mem_write_en_in;
    assign hit     = (state == IDLE) && rd_only && buf_valid_q && (buf_tag_q == wa);

    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_tag_d   = buf_tag_q;
        buf_data_d  = buf_data_q;
        // data_reg already holds the full word by the DONE cycle of a read.
        if ((state == DONE) && rd_only) begin
            buf_valid_d = 1'b1;
            buf_tag_d   = wa;
            buf_data_d  = data_reg;
        end else if ((state != IDLE) && mem_write_en_in && (buf_tag_q == wa)) begin
            buf_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_data_q  <= '0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_tag_q   <= buf_tag_d;
            buf_data_q  <= buf_data_d;
        end
    end

    assign mem_data = hit ? buf_data_q : data_reg;
`else
    assign hit      = 1'b0;
    assign mem_data = data_reg;
`endif

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory stage of the ARM pipeline. It sits between the EXE/MEM and MEM/WB pipeline registers and performs loads and stores for the instruction in MEM against an external 16-bit-wide SRAM, two half-word phases per 32-bit word. While an access is in flight it drives `ready` low to freeze the pipeline, and it passes write-back control and the ALU result through to the WB side.

## Interface
- `ADDR_BASE`, 1024: byte address that maps to SRAM word 0.
- `SRAM_WAIT`, 4: cycles per half-word phase; legal range is ≥2.
- `SRAM_AW`, 18: SRAM half-word address width.

- `clk` input, 1 bit: sole clock, rising edge.
- `rst` input, 1 bit: reset, synchronous and active-high.
- `wb_en_in`, `mem_read_en_in`, `mem_write_en_in` input, 1 bit each: control from EXE/MEM.
- `alu_res_in` input, 32 bits: effective byte address, or the ALU result for non-memory instructions.
- `val_Rm` input, 32 bits: store data.
- `dest_in` input, 4 bits: destination register.
- `wb_en` output, 1 bit: write-back enable, equal to `wb_en_in & ready`.
- `mem_read_en` output, 1 bit: `mem_read_en_in` passed through.
- `alu_res` output, 32 bits: `alu_res_in` passed through.
- `dest` output, 4 bits: `dest_in` passed through.
- `mem_data` output, 32 bits: load result.
- `ready` output, 1 bit: 0 freezes every pipeline register and the PC.
- `sram_addr` output, `SRAM_AW` bits: SRAM half-word address.
- `sram_wdata` output, 16 bits: SRAM write data.
- `sram_rdata` input, 16 bits: SRAM read data.
- `sram_we_n`, `sram_oe_n` output, 1 bit each: active-low write and output strobes.

## Operation
- Word address: `wa = (alu_res_in - ADDR_BASE) >> 2`, taken modulo 2^(`SRAM_AW`-1), so out-of-range addresses wrap. The low half-word lives at `{wa,0}` and the high half-word at `{wa,1}`.
- The FSM has four states: IDLE, LO, HI, DONE.
  - IDLE: if a read or a write is requested, go to LO; otherwise stay.
  - LO: stay `SRAM_WAIT` cycles, then go to HI.
  - HI: stay `SRAM_WAIT` cycles, then go to DONE.
  - DONE: one cycle, then go to IDLE.
- `ready` = no request in IDLE, OR state is DONE, OR a buffer hit occurs (see Configuration).
- Write:
  - `sram_wdata` carries `val_Rm[15:0]` during LO and `val_Rm[31:16]` during HI.
  - `sram_we_n` is 0 for every phase cycle except the last one of each phase (the hold cycle).
- Read:
  - `sram_oe_n` is 0 throughout LO and HI.
  - `sram_rdata` is captured on the last cycle of each phase into `data_reg[15:0]` and `data_reg[31:16]` respectively.
  - `mem_data` = `data_reg`. It holds its value until the next read completes.
- Read and write asserted together: the write takes precedence and `data_reg` is unchanged.
- Idle values: `sram_addr`=0, `sram_wdata`=0, `sram_we_n`=1, `sram_oe_n`=1.
- Reset (including mid-access):
  - The next state is IDLE and `data_reg` is cleared to 0.
  - Strobes are deasserted.
  - The abandoned access is not resumed.

## Timing
- Non-memory instruction: `ready`=1 in the same cycle, zero stall.
- Memory access (no hit): `ready` is 0 for 1+2·`SRAM_WAIT` cycles and 1 during DONE. With `SRAM_WAIT`=4, `ready` rises in the 10th cycle after the request appears.
- Upstream holds all inputs stable while `ready`=0. The instruction leaves MEM on the edge that ends DONE.
- A back-to-back memory instruction is seen in IDLE on the following cycle and starts a new access immediately.
- `wb_en`, `mem_read_en`, `alu_res`, `dest` and `ready` are combinational from inputs and state. `mem_data` is registered, or muxed on a hit.

## Configuration
- Macro `MEM_READ_HIT_BUF_EN` adds a one-entry read buffer: valid bit, word-address tag, 32-bit data.
  - The buffer is filled when a read completes.
  - It is invalidated by a write to the tagged word, and by reset.
  - A read in IDLE whose `wa` matches a valid tag produces `ready`=1 in the same cycle. `mem_data` is the buffered data and no SRAM strobes are driven.
- Without `MEM_READ_HIT_BUF_EN`, every read takes the full latency.

## Structure
- Package `mem_stage_pkg` holds:
  - the state enum (IDLE/LO/HI/DONE);
  - the `ADDR_BASE`, `SRAM_WAIT` and `SRAM_AW` defaults;
  - the SRAM data width constant (16).
- One sub-module, `sram_ctrl`, contains the FSM, phase counter, strobes and read capture.
- `mem_stage` wraps it with the pass-through logic, the address translation, and the optional hit buffer.

## Test plan
All scenarios use `SRAM_WAIT`=4 and `ADDR_BASE`=1024.
- Write with `alu_res_in`=1028, `val_Rm`=0xDEADBEEF -> `sram_addr` 2 then 3, `sram_wdata` 0xBEEF then 0xDEAD, `sram_we_n` low 3 cycles per phase, `ready` low 9 cycles.
- Read 1028 with the SRAM model holding the data above -> `mem_data`=0xDEADBEEF when `ready` rises, `wb_en`=1 only in the DONE cycle.
- Non-memory instruction, `wb_en_in`=1, `alu_res_in`=7 -> `ready`=1, `wb_en`=1, `alu_res`=7, no strobes.
- `rst` pulsed in the second HI cycle of a write -> next cycle IDLE, `sram_we_n`=1, `mem_data`=0, no further SRAM writes.
- Back-to-back reads of 1024 and 1032 -> two full 10-cycle accesses with `sram_addr` 0/1 then 4/5.
- With `MEM_READ_HIT_BUF_EN`:
  - a repeat read of 1028 -> `ready`=1 in the same cycle, `mem_data`=0xDEADBEEF;
  - after a write to 1028, a read of 1028 -> full latency again.
